// File: rtl/irq_pkg.sv
// Shared constants and per-line state type for the interrupt pending latch.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int ID_W  = $clog2(N_IRQ);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        ACTIVE  = 2'b10
    } line_state_e;

endpackage

// File: rtl/irq_line_cell.sv
// One interrupt line: trigger detection, IDLE/PENDING/ACTIVE state and the
// relatch bit that remembers an edge seen while the line is in service.
module irq_line_cell
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic claim,
    input  logic eoi,
    output logic pending,
    output logic active
);

    line_state_e state, state_nxt;
    logic        irq_q;
    logic        relatch, relatch_nxt;
    logic        trig, edge_trig;

    always_comb begin
        trig      = edge_mode ? (irq_in & ~irq_q) : irq_in;
        edge_trig = edge_mode & trig;
    end

    always_comb begin
        state_nxt   = state;
        relatch_nxt = relatch;
        case (state)
            IDLE: begin
                if (trig) state_nxt = PENDING;
            end
            PENDING: begin
                // Triggers while pending coalesce; an edge coincident with the
                // claim is remembered so it is not lost across the service.
                if (claim) begin
                    state_nxt   = ACTIVE;
                    relatch_nxt = edge_trig;
                end
            end
            ACTIVE: begin
                if (eoi) begin
                    state_nxt   = (relatch | edge_trig) ? PENDING : IDLE;
                    relatch_nxt = 1'b0;
                end else if (edge_trig) begin
                    relatch_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                relatch_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            relatch <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            relatch <= relatch_nxt;
            irq_q   <= irq_in;
        end
    end

    assign pending = (state == PENDING);
    assign active  = (state == ACTIVE);

endmodule

// File: rtl/irq_pending_latch.sv
// Eight-line interrupt front-end: per-line pending/active state, mask gating
// toward the priority encoder, and claim/EOI handshake with error pulses.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] edge_mode,
    input  logic [N_IRQ-1:0] mask,
    input  logic             claim_valid,
    input  logic [ID_W-1:0]  claim_id,
    input  logic             eoi_valid,
    input  logic [ID_W-1:0]  eoi_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] active,
    output logic [N_IRQ-1:0] req_vec,
    output logic             req_any,
    output logic             claim_err,
    output logic             eoi_err
);

    logic [N_IRQ-1:0] claim_hit, eoi_hit;

    // Each line sees its own strobe; validity against state is judged in-cell,
    // so a bad ID simply produces no transition.
    always_comb begin
        claim_hit = claim_valid ? (N_IRQ'(1) << claim_id) : '0;
        eoi_hit   = eoi_valid   ? (N_IRQ'(1) << eoi_id)   : '0;
    end

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irq_line_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_in    (irq_in[i]),
            .edge_mode (edge_mode[i]),
            .claim     (claim_hit[i]),
            .eoi       (eoi_hit[i]),
            .pending   (pending[i]),
            .active    (active[i])
        );
    end

    assign req_vec = pending & mask;
    assign req_any = |req_vec;

    // Errors are judged against pre-edge state, matching the cells.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            claim_err <= 1'b0;
            eoi_err   <= 1'b0;
        end else begin
            claim_err <= claim_valid & ~pending[claim_id];
            eoi_err   <= eoi_valid & ~active[eoi_id];
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with an expected-result queue.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in, edge_mode, mask;
    logic       claim_valid, eoi_valid;
    logic [2:0] claim_id, eoi_id;
    logic [7:0] pending, active, req_vec;
    logic       req_any, claim_err, eoi_err;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string      tag;
        logic [7:0] p, a, rv;
        logic       ra, ce, ee;
    } exp_t;

    exp_t sb[$];

    irq_pending_latch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .edge_mode   (edge_mode),
        .mask        (mask),
        .claim_valid (claim_valid),
        .claim_id    (claim_id),
        .eoi_valid   (eoi_valid),
        .eoi_id      (eoi_id),
        .pending     (pending),
        .active      (active),
        .req_vec     (req_vec),
        .req_any     (req_any),
        .claim_err   (claim_err),
        .eoi_err     (eoi_err)
    );

    always #5 clk = ~clk;

    task automatic cmp8(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    endtask

    task automatic push(input string tag, input logic [7:0] p, input logic [7:0] a,
                        input logic ce, input logic ee);
        exp_t e;
        e.tag = tag; e.p = p; e.a = a;
        e.rv = p & mask; e.ra = |(p & mask);
        e.ce = ce; e.ee = ee;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp8(e.tag, "pending",   pending,         e.p);
        cmp8(e.tag, "active",    active,          e.a);
        cmp8(e.tag, "req_vec",   req_vec,         e.rv);
        cmp8(e.tag, "req_any",   {7'd0, req_any}, {7'd0, e.ra});
        cmp8(e.tag, "claim_err", {7'd0, claim_err}, {7'd0, e.ce});
        cmp8(e.tag, "eoi_err",   {7'd0, eoi_err},   {7'd0, e.ee});
    endtask

    // Inputs are already set; expected state after the next rising edge.
    task automatic step(input string tag, input logic [7:0] p, input logic [7:0] a,
                        input logic ce = 1'b0, input logic ee = 1'b0);
        push(tag, p, a, ce, ee);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        claim_valid = 1'b0;
        eoi_valid   = 1'b0;
    endtask

    task automatic claim(input logic [2:0] id);
        claim_valid = 1'b1; claim_id = id;
    endtask

    task automatic eoi(input logic [2:0] id);
        eoi_valid = 1'b1; eoi_id = id;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = 8'h00; edge_mode = 8'h00; mask = 8'hFF;
        claim_valid = 1'b0; claim_id = 3'd0; eoi_valid = 1'b0; eoi_id = 3'd0;
        @(negedge clk);

        // 1: level mode
        step("reset", 8'h00, 8'h00);
        rst_n = 1'b1;
        irq_in = 8'h20;       step("lvl_pend",  8'h20, 8'h00);
        claim(3'd5);          step("claim5",    8'h00, 8'h20);
                              step("hold5",     8'h00, 8'h20);
        eoi(3'd5);            step("eoi5",      8'h00, 8'h00);
                              step("repend5",   8'h20, 8'h00);
        irq_in = 8'h00; claim(3'd5); step("claim5b", 8'h00, 8'h20);
        eoi(3'd5);            step("eoi5b",     8'h00, 8'h00);

        // 2: edge mode, coalescing and relatch
        edge_mode = 8'h04;
        irq_in = 8'h04;       step("e_p1",      8'h04, 8'h00);
        irq_in = 8'h00;       step("e_l1",      8'h04, 8'h00);
        irq_in = 8'h04;       step("e_p2",      8'h04, 8'h00);
        irq_in = 8'h00;       step("e_l2",      8'h04, 8'h00);
        irq_in = 8'h04;       step("e_p3",      8'h04, 8'h00);
        irq_in = 8'h00;       step("e_l3",      8'h04, 8'h00);
        claim(3'd2);          step("claim2",    8'h00, 8'h04);
        irq_in = 8'h04;       step("e_act",     8'h00, 8'h04);
        irq_in = 8'h00;       step("e_actl",    8'h00, 8'h04);
        eoi(3'd2);            step("eoi2_rel",  8'h04, 8'h00);
        claim(3'd2);          step("claim2b",   8'h00, 8'h04);
        eoi(3'd2);            step("eoi2_clr",  8'h00, 8'h00);

        // 3: mask gating
        edge_mode = 8'h00; mask = 8'h7F;
        irq_in = 8'h80;       step("m_pend",    8'h80, 8'h00);
        irq_in = 8'h00;       step("m_hold",    8'h80, 8'h00);
        mask = 8'hFF; #1;
        push("m_comb", 8'h80, 8'h00, 1'b0, 1'b0);
        pop_check();
        claim(3'd7);          step("claim7",    8'h00, 8'h80);
        eoi(3'd7);            step("eoi7",      8'h00, 8'h00);

        // 4: errors
        claim(3'd3);          step("claim_err", 8'h00, 8'h00, 1'b1, 1'b0);
                              step("claim_clr", 8'h00, 8'h00);
        eoi(3'd6);            step("eoi_err",   8'h00, 8'h00, 1'b0, 1'b1);
                              step("eoi_clr",   8'h00, 8'h00);

        // 5: nested active lines, simultaneous EOI and claim
        irq_in = 8'h52;       step("n_pend",    8'h52, 8'h00);
        irq_in = 8'h00;       step("n_hold",    8'h52, 8'h00);
        claim(3'd1);          step("claim1",    8'h50, 8'h02);
        claim(3'd4);          step("claim4",    8'h40, 8'h12);
        eoi(3'd1); claim(3'd6); step("eoi1_cl6", 8'h00, 8'h50);

        // same-ID claim and EOI on a pending line: claim wins, EOI errors
        edge_mode = 8'h01; irq_in = 8'h01; step("p0", 8'h01, 8'h50);
        claim(3'd0); eoi(3'd0); step("ce_same", 8'h00, 8'h51, 1'b0, 1'b1);
        eoi(3'd0);            step("eoi0",      8'h00, 8'h50);

        // 6: reset mid-handshake; edge line held high through reset
        irq_in = 8'h00;       step("p0_low",    8'h00, 8'h50);
        irq_in = 8'h01;       step("p0_edge",   8'h01, 8'h50);
        rst_n = 1'b0;         step("rst2",      8'h00, 8'h00);
        rst_n = 1'b1;         step("post_rst",  8'h01, 8'h00);
                              step("post_hold", 8'h01, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Eight-line interrupt front-end sitting directly upstream of the team's 8:3 priority encoder.
- Captures level- or edge-triggered requests into per-line pending state and applies a mask.
- Presents the masked request vector and an "any request" flag; these drive the encoder's input bus and enable.
- Runs a claim / end-of-interrupt (EOI) handshake keyed by the 3-bit ID the encoder produces.

Parameters:
- N_IRQ, 8, number of request lines; fixed at 8 in this revision.
- ID_W, 3, width of claim/EOI IDs, equal to clog2(N_IRQ).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- irq_in  input  8  raw request lines, already synchronous to clk.
- edge_mode  input  8  per line: 1 = rising-edge triggered, 0 = level triggered.
- mask  input  8  per line: 1 = enabled to req_vec, 0 = suppressed; does not affect latching.
- claim_valid  input  1  single-cycle claim strobe.
- claim_id  input  3  line being claimed; normally the encoder output.
- eoi_valid  input  1  single-cycle end-of-interrupt strobe.
- eoi_id  input  3  line being completed.
- pending  output  8  registered per-line PENDING flags.
- active  output  8  registered per-line ACTIVE (in-service) flags.
- req_vec  output  8  pending & mask, combinational from registered pending; feeds encoder input.
- req_any  output  1  OR of req_vec; feeds encoder enable.
- claim_err  output  1  registered one-cycle pulse: claim of a line not PENDING.
- eoi_err  output  1  registered one-cycle pulse: EOI of a line not ACTIVE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All lines go to IDLE; pending, active, relatch bits, irq_q, claim_err and eoi_err are cleared.
  - req_vec and req_any are therefore 0.
  - irq_q resets to 0, so an edge-mode line held high through reset registers one edge on the first cycle after release.
  - Reset mid-handshake discards all in-service state; no error pulses are generated.
- Trigger, per line i:
  - Level mode: trig_i = irq_in[i].
  - Edge mode: trig_i = irq_in[i] & ~irq_q[i], where irq_q is irq_in registered every cycle.
- Per-line state machine (states encoded by the pending/active bits):
  - IDLE -> PENDING when trig_i.
  - PENDING -> ACTIVE on claim_valid with claim_id == i. Further triggers while PENDING are coalesced.
  - ACTIVE -> IDLE on eoi_valid with eoi_id == i, or ACTIVE -> PENDING if relatch_i is set.
  - Edge-mode trigger while ACTIVE sets relatch_i. Level mode never uses relatch; a still-high level re-pends from IDLE on the next cycle.
  - relatch_i clears on the transition out of ACTIVE.
- Latency:
  - Trigger at edge n gives pending[i]=1 and req_vec visible after edge n.
  - Claim at edge n gives pending[i]=0 and active[i]=1 after edge n.
  - EOI behaves the same way (one register stage).
  - mask acts combinationally on req_vec (zero cycle).
- Simultaneous events:
  - Claim and EOI in the same cycle on different IDs: both are applied.
  - Claim and EOI on the same ID: the claim is evaluated against the pre-edge state; the EOI is an error if the line was not ACTIVE.
  - Edge-mode trigger in the same cycle as a claim of that line: the line goes ACTIVE with relatch set.
  - Edge-mode trigger in the same cycle as an EOI of that line: the line goes PENDING.
  - Level-mode trigger in the same cycle as an EOI: the line goes IDLE, then PENDING on the next cycle if still high.
- Errors:
  - Claim of a non-PENDING line (including a masked-but-pending line, which is legal and accepted) has no state change and raises claim_err for 1 cycle.
  - EOI of a non-ACTIVE line has no state change and raises eoi_err for 1 cycle.
- Multiple lines may be ACTIVE at once (nesting is permitted); prioritisation is entirely downstream.
- Changing edge_mode while a line is PENDING or ACTIVE leaves its state unchanged; only the next trigger evaluation uses the new mode.

Decomposition:
- Shared package irq_pkg: N_IRQ, ID_W, and a per-line state typedef {IDLE, PENDING, ACTIVE}.
- Natural sub-module: irq_line_cell, one line's trigger detection, state and relatch bit, instantiated 8 times.
- The top level holds the claim/EOI ID decoders, the mask gating, and the error-pulse registers.

Test Plan:
1. Reset with irq_in=8'h00, then level-mode irq_in[5]=1, mask=8'hFF: pending=8'h20 and req_any=1 one cycle later; claim_id=5 gives active=8'h20, pending=0; EOI 5 with irq still high gives PENDING again 2 cycles after the EOI.
2. Edge mode on line 2, three pulses while PENDING: a single pending bit; claim 2, then one pulse while ACTIVE: relatch set; EOI 2 gives pending=8'h04 the next cycle.
3. mask=8'h7F with line 7 pending: req_vec=0 and req_any=0, pending=8'h80; set mask=8'hFF: req_vec=8'h80 in the same cycle.
4. Claim ID 3 while line 3 is IDLE: claim_err pulses for exactly 1 cycle and pending/active are unchanged; EOI ID 6 while line 6 is not ACTIVE: eoi_err pulses.
5. Lines 1 and 4 ACTIVE, same-cycle EOI 1 and claim 6 (6 PENDING): active=8'h50 next cycle, no errors.
6. Lines pending and active, rst_n low for 1 cycle: all outputs 0; an edge-mode line held high through reset becomes pending on the first cycle after release.
